led_bar_decoder: RTL and testbench

Receive-side decoder and checker for the 8-bit LED bar animation bus. It samples the bar pattern on each frame strobe from the pacing counter and recovers the 16-step animation index: fill steps 0–7, drain steps 8–14, blank step 15. It also verifies that successive frames follow the legal sequence and counts violations. It sits on the animation output bus as a self-check monitor and as the frame-index source for downstream logic.

---
 rtl/led_bar_decoder_if.sv | 12 +
 rtl/led_bar_decoder.sv | 94 +++++++++
 tb/tb_led_bar_decoder.sv | 131 +++++++++++++
 3 files changed

// File: rtl/led_bar_decoder_if.sv
// led_bar_decoder_if: LED bar animation bus carrying observed frames in and decoded step/status out
interface led_bar_decoder_if #(parameter int ERR_W = 8) ();
  logic [7:0]       led_in;
  logic             sample;
  logic [3:0]       step;
  logic             step_valid;
  logic             dir;
  logic             seq_err;
  logic [ERR_W-1:0] err_cnt;
  modport master (output led_in, sample, input step, step_valid, dir, seq_err, err_cnt);
  modport slave (input led_in, sample, output step, step_valid, dir, seq_err, err_cnt);
endinterface

// File: rtl/led_bar_decoder.sv
// led_bar_decoder: recovers the 16-step fill/drain animation index and counts sequence errors
// LED_BAR_BLINK_TOL_EN: ignore the blinking fill-front bit s when checking fill steps 0-7
module led_bar_decoder #(
  parameter int LOCK_CNT = 2,
  parameter int MISS_MAX = 3,
  parameter int ERR_W    = 8
) (
  input logic clk,
  input logic rst,
  led_bar_decoder_if.slave bus
);
  typedef enum logic [1:0] {HUNT, CONFIRM, LOCKED} state_t;
  state_t           fsm, w_fsm;
  logic [3:0]       exp, ccnt, mcnt, r_step;
  logic [3:0]       w_exp, w_ccnt, w_mcnt, w_step;
  logic             r_dir, r_step_valid, r_seq_err, w_seq_err, w_hit;
  logic [ERR_W-1:0] r_err_cnt;
  function automatic logic [7:0] pat(input logic [3:0] s);
    return s[3] ? 8'hFF >> ({1'b0, s[2:0]} + 4'd1) : 8'hFF >> (3'd7 - s[2:0]);
  endfunction
  function automatic logic hit(input logic [7:0] v, input logic [3:0] s);
    logic [7:0] m;
`ifdef LED_BAR_BLINK_TOL_EN
    m = s[3] ? 8'hFF : ~(8'h01 << s[2:0]);
`else
    m = 8'hFF;
`endif
    return ((v ^ pat(s)) & m) == 8'h00;
  endfunction
  always_comb begin
    w_fsm     = fsm;
    w_exp     = exp;
    w_ccnt    = ccnt;
    w_mcnt    = mcnt;
    w_step    = r_step;
    w_seq_err = 1'b0;
    w_hit     = hit(bus.led_in, exp);
    if (bus.sample) begin
      case (fsm)
        HUNT: begin
          if (hit(bus.led_in, 4'd7) || hit(bus.led_in, 4'd15)) begin
            w_step = hit(bus.led_in, 4'd7) ? 4'd7 : 4'd15;
            w_exp  = w_step + 4'd1;
            w_ccnt = 4'd0;
            w_fsm  = CONFIRM;
          end
        end
        CONFIRM: begin
          w_step = w_hit ? exp : r_step;
          w_exp  = w_hit ? exp + 4'd1 : exp;
          w_ccnt = w_hit ? ccnt + 4'd1 : ccnt;
          w_mcnt = 4'd0;
          w_fsm  = !w_hit ? HUNT : (w_ccnt == 4'(LOCK_CNT)) ? LOCKED : CONFIRM;
        end
        LOCKED: begin
          w_step    = exp;
          w_exp     = exp + 4'd1;
          w_mcnt    = w_hit ? 4'd0 : mcnt + 4'd1;
          w_seq_err = !w_hit;
          w_fsm     = (w_mcnt == 4'(MISS_MAX)) ? HUNT : LOCKED;
        end
        default: w_fsm = HUNT;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm          <= HUNT;
      exp          <= 4'd0;
      ccnt         <= 4'd0;
      mcnt         <= 4'd0;
      r_step       <= 4'd15;
      r_dir        <= 1'b0;
      r_step_valid <= 1'b0;
      r_seq_err    <= 1'b0;
      r_err_cnt    <= '0;
    end else begin
      fsm          <= w_fsm;
      exp          <= w_exp;
      ccnt         <= w_ccnt;
      mcnt         <= w_mcnt;
      r_step       <= w_step;
      r_dir        <= ~w_step[3];
      r_step_valid <= (w_fsm == LOCKED);
      r_seq_err    <= w_seq_err;
      if (w_seq_err && !(&r_err_cnt)) r_err_cnt <= r_err_cnt + 1'b1;
    end
  end
  assign bus.step       = r_step;
  assign bus.dir        = r_dir;
  assign bus.step_valid = r_step_valid;
  assign bus.seq_err    = r_seq_err;
  assign bus.err_cnt    = r_err_cnt;
endmodule

// File: tb/tb_led_bar_decoder.sv
// tb_led_bar_decoder: directed frame sequences for lock, tracking, errors, lock loss, reset and blink tolerance
module tb_led_bar_decoder;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] e_tab [16] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                             8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00};
  led_bar_decoder_if #(.ERR_W(8)) bus ();
  led_bar_decoder #(.LOCK_CNT(2), .MISS_MAX(3), .ERR_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", tag, got, want);
    end
  endtask
  task automatic frame(input logic [7:0] v);
    bus.led_in = v;
    bus.sample = 1'b1;
    @(negedge clk);
    bus.sample = 1'b0;
  endtask
  initial begin
    rst = 1'b1;
    bus.sample = 1'b0;
    bus.led_in = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_step", bus.step, 15);
    chk("rst_dir", bus.dir, 0);
    chk("rst_valid", bus.step_valid, 0);
    chk("rst_seq_err", bus.seq_err, 0);
    chk("rst_err_cnt", bus.err_cnt, 0);
    rst = 1'b0;
    frame(8'h00);
    chk("anchor_step", bus.step, 15);
    chk("anchor_valid", bus.step_valid, 0);
    frame(8'h01);
    chk("conf1_step", bus.step, 0);
    chk("conf1_valid", bus.step_valid, 0);
    frame(8'h03);
    chk("lock_step", bus.step, 1);
    chk("lock_valid", bus.step_valid, 1);
    frame(8'h07);
    chk("locked_step", bus.step, 2);
    chk("locked_err_cnt", bus.err_cnt, 0);
    chk("locked_dir", bus.dir, 1);
    for (int s = 3; s < 16; s++) begin
      frame(e_tab[s]);
      chk("cycle_step", bus.step, s);
      chk("cycle_seq_err", bus.seq_err, 0);
      if (s == 8) chk("dir_fall", bus.dir, 0);
    end
    frame(e_tab[0]);
    chk("wrap_step", bus.step, 0);
    chk("dir_rise", bus.dir, 1);
    chk("wrap_valid", bus.step_valid, 1);
    for (int s = 1; s < 9; s++) frame(e_tab[s]);
    frame(8'h1F);
    chk("err1_seq_err", bus.seq_err, 1);
    chk("err1_err_cnt", bus.err_cnt, 1);
    chk("err1_step", bus.step, 9);
    @(negedge clk);
    chk("err1_pulse_end", bus.seq_err, 0);
    frame(e_tab[10]);
    chk("recover_step", bus.step, 10);
    chk("recover_seq_err", bus.seq_err, 0);
    chk("recover_valid", bus.step_valid, 1);
    for (int i = 0; i < 3; i++) begin
      frame(8'hAA);
      chk("miss_seq_err", bus.seq_err, 1);
      chk("miss_step", bus.step, 11 + i);
      chk("miss_valid", bus.step_valid, (i < 2) ? 1 : 0);
    end
    chk("miss_err_cnt", bus.err_cnt, 4);
    frame(8'h0F);
    chk("hunt_valid", bus.step_valid, 0);
    chk("hunt_seq_err", bus.seq_err, 0);
    chk("hunt_step", bus.step, 13);
    chk("hunt_err_cnt", bus.err_cnt, 4);
    frame(8'hFF);
    chk("reanchor_step", bus.step, 7);
    chk("reanchor_valid", bus.step_valid, 0);
    frame(8'h7F);
    chk("reconf_valid", bus.step_valid, 0);
    frame(8'h3F);
    chk("relock_step", bus.step, 9);
    chk("relock_valid", bus.step_valid, 1);
    chk("relock_dir", bus.dir, 0);
    for (int s = 10; s < 16; s++) frame(e_tab[s]);
    for (int s = 0; s < 5; s++) frame(e_tab[s]);
    chk("pre_rst_step", bus.step, 4);
    rst = 1'b1;
    bus.led_in = e_tab[5];
    bus.sample = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.sample = 1'b0;
    chk("midrst_step", bus.step, 15);
    chk("midrst_valid", bus.step_valid, 0);
    chk("midrst_err_cnt", bus.err_cnt, 0);
    chk("midrst_dir", bus.dir, 0);
    frame(8'h01);
    chk("postrst_hunt_step", bus.step, 15);
    chk("postrst_hunt_valid", bus.step_valid, 0);
`ifdef LED_BAR_BLINK_TOL_EN
    frame(8'h00);
    frame(8'h00);
    chk("blink_step0", bus.step, 0);
    frame(8'h01);
    chk("blink_lock", bus.step_valid, 1);
    frame(8'h03);
    frame(8'h07);
    chk("blink_step", bus.step, 3);
    chk("blink_seq_err", bus.seq_err, 0);
    chk("blink_err_cnt", bus.err_cnt, 0);
`else
    frame(8'h00);
    frame(8'h01);
    frame(8'h05);
    frame(8'h3F);
    frame(8'h7F);
    chk("noblink_valid", bus.step_valid, 0);
    chk("noblink_step", bus.step, 0);
    chk("noblink_err_cnt", bus.err_cnt, 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
